// File: rtl/wb_stage.sv
// MEM/WB pipeline register and writeback stage: load alignment, writeback select,
// load-response wait, single retirement and instret. Optional bypass: WB_BYPASS_EN.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_rd,
    input  logic [1:0]  mem_wbsel,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_alu_out,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_imm,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    output logic        rf_load,
    output logic [4:0]  rf_dest,
    output logic [31:0] rf_in,
    output logic        wb_stall_req,
    output logic        retire_valid,
    output logic [63:0] instret,
    output logic [31:0] id_rs1_val,
    output logic [31:0] id_rs2_val
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 64;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_IMM  = 2'b11
    } wbsel_e;

    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic [REG_W-1:0] rd;
        logic [1:0]       wbsel;
        logic [2:0]       funct3;
        logic [XLEN-1:0]  alu_out;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic             done;
    } wb_reg_t;

    wb_reg_t          wb_q, wb_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             hold;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [XLEN-1:0]  load_data;

    assign wb_stall_req = wb_q.valid & ~wb_q.done & (wb_q.wbsel == WB_LOAD) & ~dmem_resp;
    assign retire_valid = wb_q.valid & ~wb_q.done & ~wb_stall_req;
    assign rf_load      = retire_valid & wb_q.regwrite & (wb_q.rd != '0);
    assign rf_dest      = wb_q.rd;
    assign instret      = instret_q;
    assign hold         = stall | wb_stall_req;

    // Extract and extend the addressed byte/halfword from the aligned word
    always_comb begin
        ld_byte = dmem_rdata[{wb_q.alu_out[1:0], 3'b000} +: 8];
        ld_half = wb_q.alu_out[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (wb_q.funct3)
            3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {24'd0, ld_byte};
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_data = {16'd0, ld_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        case (wb_q.wbsel)
            WB_ALU:  rf_in = wb_q.alu_out;
            WB_LOAD: rf_in = load_data;
            WB_PC4:  rf_in = XLEN'(wb_q.pc + 32'd4);
            default: rf_in = wb_q.imm;
        endcase
    end

    // Register update: reset > hold > flush > capture
    always_comb begin
        wb_d      = wb_q;
        instret_d = instret_q;
        if (rst) begin
            wb_d      = '0;
            instret_d = '0;
        end else begin
            if (retire_valid) begin
                instret_d = CNT_W'(instret_q + 64'd1);
            end
            if (hold) begin
                wb_d.done = wb_q.done | retire_valid;
            end else if (flush) begin
                wb_d.valid = 1'b0;
                wb_d.done  = 1'b0;
            end else begin
                wb_d.valid    = mem_valid;
                wb_d.regwrite = mem_regwrite;
                wb_d.rd       = mem_rd;
                wb_d.wbsel    = mem_wbsel;
                wb_d.funct3   = mem_funct3;
                wb_d.alu_out  = mem_alu_out;
                wb_d.pc       = mem_pc;
                wb_d.imm      = mem_imm;
                wb_d.done     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        wb_q      <= wb_d;
        instret_q <= instret_d;
    end

`ifdef WB_BYPASS_EN
    // Forward the write in flight to decode; rd=0 never asserts rf_load
    always_comb begin
        id_rs1_val = (rf_load && (id_rs1 == rf_dest)) ? rf_in : rf_rs1_data;
        id_rs2_val = (rf_load && (id_rs2 == rf_dest)) ? rf_in : rf_rs2_data;
    end
`else
    logic unused_id_rs;
    assign unused_id_rs = ^{id_rs1, id_rs2};
    always_comb begin
        id_rs1_val = rf_rs1_data;
        id_rs2_val = rf_rs2_data;
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver models each instruction's retirement,
// monitor pops expectations whenever the DUT retires.
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst, stall, flush, mem_valid, mem_regwrite, dmem_resp;
    logic [4:0]  mem_rd, id_rs1, id_rs2, rf_dest;
    logic [1:0]  mem_wbsel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_out, mem_pc, mem_imm, dmem_rdata, rf_rs1_data, rf_rs2_data;
    logic        rf_load, wb_stall_req, retire_valid;
    logic [31:0] rf_in, id_rs1_val, id_rs2_val;
    logic [63:0] instret;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
        .mem_wbsel(mem_wbsel), .mem_funct3(mem_funct3), .mem_alu_out(mem_alu_out),
        .mem_pc(mem_pc), .mem_imm(mem_imm), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .rf_load(rf_load), .rf_dest(rf_dest), .rf_in(rf_in), .wb_stall_req(wb_stall_req),
        .retire_valid(retire_valid), .instret(instret),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val)
    );

    typedef struct {
        bit rst, stall, flush, valid, regwrite, resp, hit1, hit2;
        bit [4:0] rd, rs1, rs2;
        bit [1:0] wbsel;
        bit [2:0] f3;
        bit [31:0] alu, pc, imm, ld, d1, d2;
    } stim_t;

    // One instruction sitting in WB, with its writeback value already worked out
    typedef struct {
        bit valid, isld, done, regw;
        bit [4:0] rd;
        bit [31:0] val, ld;
    } slot_t;

    typedef struct {
        bit load;
        bit [4:0] dest;
        bit [31:0] data;
        longint unsigned cnt;
    } exp_t;

    exp_t            q[$];
    slot_t           cur, nxt;
    longint unsigned count;
    bit              exp_stall, mon_en;
    bit [31:0]       exp_v1, exp_v2;
    int              n_vec, n_err;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic bit [31:0] load_model(bit [2:0] f3, bit [31:0] addr, bit [31:0] w);
        bit [31:0] b, h;
        b = (w >> (8 * addr[1:0])) & 32'hFF;
        h = (w >> (16 * addr[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'h80)   ? b + 32'hFFFFFF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'h8000) ? h + 32'hFFFF0000 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit [31:0] wb_value(stim_t s);
        case (s.wbsel)
            2'd0:    return s.alu;
            2'd1:    return load_model(s.f3, s.alu, s.ld);
            2'd2:    return s.pc + 32'd4;
            default: return s.imm;
        endcase
    endfunction

    function automatic stim_t idle();
        stim_t s = '{default: 0};
        s.rs1 = 5'($urandom); s.rs2 = 5'($urandom);
        s.d1 = $urandom; s.d2 = $urandom;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s = idle();
        s.rst      = ($urandom_range(0, 99) == 0);
        s.stall    = ($urandom_range(0, 4) == 0);
        s.flush    = ($urandom_range(0, 9) == 0);
        s.valid    = ($urandom_range(0, 5) != 0);
        s.regwrite = ($urandom_range(0, 4) != 0);
        s.rd       = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        s.wbsel    = 2'($urandom);
        s.f3       = 3'($urandom);
        s.alu = $urandom; s.pc = $urandom; s.imm = $urandom; s.ld = $urandom;
        s.resp     = ($urandom_range(0, 2) == 0);
        s.hit1     = ($urandom_range(0, 2) == 0);
        s.hit2     = ($urandom_range(0, 2) == 0);
        return s;
    endfunction

    // Drive one cycle and predict what WB does during it
    task automatic step(input stim_t s);
        bit pend, ret, wr;
        @(posedge clk); #1;
        cur = nxt;
        if (s.hit1) s.rs1 = cur.rd;
        if (s.hit2) s.rs2 = cur.rd;
        rst = s.rst; stall = s.stall; flush = s.flush;
        mem_valid = s.valid; mem_regwrite = s.regwrite; mem_rd = s.rd;
        mem_wbsel = s.wbsel; mem_funct3 = s.f3; mem_alu_out = s.alu;
        mem_pc = s.pc; mem_imm = s.imm; dmem_resp = s.resp;
        dmem_rdata = (cur.valid && cur.isld) ? cur.ld : $urandom;
        id_rs1 = s.rs1; id_rs2 = s.rs2; rf_rs1_data = s.d1; rf_rs2_data = s.d2;

        pend = cur.valid && !cur.done && cur.isld && !s.resp;
        ret  = cur.valid && !cur.done && !pend;
        wr   = ret && cur.regw && (cur.rd != 5'd0);
        exp_stall = pend;
        if (ret) begin
            q.push_back('{wr, cur.rd, cur.val, count});
            count++;
        end
`ifdef WB_BYPASS_EN
        exp_v1 = (wr && s.rs1 == cur.rd) ? cur.val : s.d1;
        exp_v2 = (wr && s.rs2 == cur.rd) ? cur.val : s.d2;
`else
        exp_v1 = s.d1;
        exp_v2 = s.d2;
`endif
        if (s.rst) begin
            nxt = '{default: 0};
            count = 0;
        end else if (s.stall || pend) begin
            nxt = cur;
            nxt.done = cur.done || ret;
        end else if (s.flush) begin
            nxt = cur;
            nxt.valid = 0;
            nxt.done = 0;
        end else begin
            nxt = '{valid: s.valid, isld: (s.wbsel == 2'd1), done: 1'b0, regw: s.regwrite,
                    rd: s.rd, val: wb_value(s), ld: s.ld};
        end
    endtask

    task automatic check_reset();
        @(negedge clk);
        chk("rst_rf_load", rf_load, 0);
        chk("rst_rf_dest", rf_dest, 0);
        chk("rst_rf_in", rf_in, 0);
        chk("rst_stall_req", wb_stall_req, 0);
        chk("rst_retire", retire_valid, 0);
        chk("rst_instret", instret, 0);
    endtask

    // Monitor: per-cycle outputs and retirement scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            bit   exp_ret;
            chk("wb_stall_req", wb_stall_req, exp_stall);
            chk("id_rs1_val", id_rs1_val, exp_v1);
            chk("id_rs2_val", id_rs2_val, exp_v2);
            exp_ret = (q.size() != 0);
            chk("retire_valid", retire_valid, exp_ret);
            if (retire_valid && exp_ret) begin
                e = q.pop_front();
                chk("rf_load", rf_load, e.load);
                chk("rf_dest", rf_dest, e.dest);
                chk("rf_in", rf_in, e.data);
                chk("instret", instret, e.cnt);
            end else begin
                chk("rf_load_idle", rf_load, 0);
                q.delete();
            end
        end
    end

    initial begin
        stim_t s;
        n_vec = 0; n_err = 0; count = 0; mon_en = 0;
        cur = '{default: 0}; nxt = '{default: 0};
        s = idle(); s.rst = 1;
        step(s); step(s);
        mon_en = 1;
        step(idle());
        check_reset();

        // lb / lbu from byte 2 of 0x12F45678
        s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 5'd3; s.wbsel = 2'd1; s.f3 = 3'd0;
        s.alu = 32'h1002; s.ld = 32'h12F45678;
        step(s);
        s.f3 = 3'd4; s.resp = 1; step(s);
        s = idle(); s.resp = 1; step(s);

        // load waiting three cycles for its response
        s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 5'd9; s.wbsel = 2'd1; s.f3 = 3'd5;
        s.alu = 32'h2003; s.ld = 32'h8001_7FFF;
        step(s);
        for (int i = 0; i < 3; i++) step(idle());
        s = idle(); s.resp = 1; step(s);
        step(idle());

        // ALU op held by external stall after retiring, then bypass to decode
        s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 5'd5; s.alu = 32'hA5A5_0001;
        step(s);
        for (int i = 0; i < 4; i++) begin
            s = idle(); s.stall = 1; s.hit1 = 1; step(s);
        end
        s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 5'd7; s.alu = 32'hDEADBEEF;
        step(s);
        s = idle(); s.hit1 = 1; s.d1 = 32'h0; step(s);

        // x0 write, then flushed capture
        s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 5'd0; s.alu = 32'h1234; s.hit1 = 1;
        step(s);
        s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 5'd4; s.flush = 1; step(s);
        step(idle());

        // JAL link wraps; reset during a pending load
        s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 5'd1; s.wbsel = 2'd2; s.pc = 32'hFFFFFFFC;
        step(s);
        s = idle(); s.valid = 1; s.regwrite = 1; s.rd = 5'd2; s.wbsel = 2'd1; s.f3 = 3'd2;
        s.ld = 32'hCAFEF00D;
        step(s);
        step(idle());
        s = idle(); s.rst = 1; step(s);
        step(idle());
        check_reset();

        for (int i = 0; i < 4000; i++) step(rand_stim());

        s = idle(); s.resp = 1;
        for (int i = 0; i < 4; i++) step(s);
        @(negedge clk);
        #1 mon_en = 0;
        chk("queue_empty", 64'(q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
